// File: rtl/lbm_div_arbiter_if.sv
// lbm_div_arbiter_if: requester and divider handshake bundle for lbm_div_arbiter
// slave : arbiter view (drives ack/result/busy and the divider operands/start)
// master: environment view (requesters plus divider)
interface lbm_div_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_numer;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_denom;
    logic [NUM_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]         result;
    logic                          busy;
    logic                          div_start;
    logic [DATA_WIDTH-1:0]         div_numer;
    logic [DATA_WIDTH-1:0]         div_denom;
    logic                          div_valid;
    logic [DATA_WIDTH-1:0]         div_quotient;
    logic                          div_zero_err;
    modport slave (
        input  req, req_numer, req_denom, div_valid, div_quotient,
        output ack, result, busy, div_start, div_numer, div_denom, div_zero_err
    );
    modport master (
        output req, req_numer, req_denom, div_valid, div_quotient,
        input  ack, result, busy, div_start, div_numer, div_denom, div_zero_err
    );
endinterface

// File: rtl/lbm_div_arbiter.sv
// lbm_div_arbiter: round-robin sharing of one iterative divider among NUM_REQ requesters
// Ports: Clk (rising edge), Reset (sync, active-high), bus (lbm_div_arbiter_if.slave):
//   req/req_numer/req_denom in, ack/result out; div_start/div_numer/div_denom out,
//   div_valid/div_quotient in; busy and div_zero_err status out.
// Optional macro LBM_DIV_ZERO_GUARD_EN: zero denominators bypass the divider and set div_zero_err.
module lbm_div_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    lbm_div_arbiter_if.slave   bus
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d, last_q, last_d, sel, j;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [DATA_WIDTH-1:0] result_q, result_d, div_numer_q, div_numer_d, div_denom_q, div_denom_d;
    logic [DATA_WIDTH-1:0] sel_numer, sel_denom;
    logic                  busy_q, busy_d, div_start_q, div_start_d;
`ifdef LBM_DIV_ZERO_GUARD_EN
    logic                  zero_err_q, zero_err_d;
`endif
    always_comb begin
        // first set request scanning upward from last_q+1; later k overwritten by lower k
        sel = last_q;
        j = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IW'((int'(last_q) + k) % NUM_REQ);
            if (bus.req[j]) sel = j;
        end
        sel_numer = bus.req_numer[sel*DATA_WIDTH +: DATA_WIDTH];
        sel_denom = bus.req_denom[sel*DATA_WIDTH +: DATA_WIDTH];
        state_d = state_q;
        idx_d = idx_q;
        last_d = last_q;
        result_d = result_q;
        div_numer_d = div_numer_q;
        div_denom_d = div_denom_q;
        div_start_d = 1'b0;
        ack_d = '0;
`ifdef LBM_DIV_ZERO_GUARD_EN
        zero_err_d = zero_err_q;
`endif
        case (state_q)
            IDLE: if (|bus.req) begin
                idx_d = sel;
                div_numer_d = sel_numer;
                div_denom_d = sel_denom;
                state_d = ISSUE;
                div_start_d = 1'b1;
`ifdef LBM_DIV_ZERO_GUARD_EN
                if (sel_denom == '0) begin
                    state_d = DONE;
                    div_start_d = 1'b0;
                    result_d = '1;
                    zero_err_d = 1'b1;
                    ack_d = NUM_REQ'(1) << sel;
                end
`endif
            end
            ISSUE: state_d = WAIT;
            WAIT: if (bus.div_valid) begin
                result_d = bus.div_quotient;
                ack_d = NUM_REQ'(1) << idx_q;
                state_d = DONE;
            end
            default: begin
                last_d = idx_q;
                state_d = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            last_q <= IW'(NUM_REQ - 1);
            ack_q <= '0;
            result_q <= '0;
            busy_q <= 1'b0;
            div_start_q <= 1'b0;
            div_numer_q <= '0;
            div_denom_q <= '0;
`ifdef LBM_DIV_ZERO_GUARD_EN
            zero_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            last_q <= last_d;
            ack_q <= ack_d;
            result_q <= result_d;
            busy_q <= busy_d;
            div_start_q <= div_start_d;
            div_numer_q <= div_numer_d;
            div_denom_q <= div_denom_d;
`ifdef LBM_DIV_ZERO_GUARD_EN
            zero_err_q <= zero_err_d;
`endif
        end
    end
    assign bus.ack = ack_q;
    assign bus.result = result_q;
    assign bus.busy = busy_q;
    assign bus.div_start = div_start_q;
    assign bus.div_numer = div_numer_q;
    assign bus.div_denom = div_denom_q;
`ifdef LBM_DIV_ZERO_GUARD_EN
    assign bus.div_zero_err = zero_err_q;
`else
    assign bus.div_zero_err = 1'b0;
`endif
endmodule
